// File: rtl/rx_tx_pkg.sv
// +---------------------------------------------------------------------------+
// | rx_tx_pkg : constants, state types and CRC-32 helper shared by RX/TX MACs |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package rx_tx_pkg;

   localparam int          DATA_WIDTH     = 8;
   localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
   localparam logic [7:0]  SFD_BYTE       = 8'hD5;
   localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_CONSTANT = 32'hDEBB20E3;

   localparam int TX_MIN_FRAME_BYTES = 60;
   localparam int TX_MAX_FRAME_BYTES = 1514;
   localparam int TX_IFG_BYTES       = 12;

   typedef enum logic [2:0] {
      TX_IDLE     = 3'd0,
      TX_PREAMBLE = 3'd1,
      TX_SFD      = 3'd2,
      TX_DATA     = 3'd3,
      TX_PAD      = 3'd4,
      TX_FCS      = 3'd5,
      TX_IFG      = 3'd6
   } tx_state_t;

   // Reflected CRC-32, one bit per step, LSB of the byte first.
   function automatic logic [31:0] crc32_next(input logic [7:0] data, input logic [31:0] crc);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tx_fcs_gen.sv
// +---------------------------------------------------------------------------+
// | tx_fcs_gen : running CRC-32 register with complemented FCS byte select    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tx_fcs_gen
   import rx_tx_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  init_i,
   input  logic                  update_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [1:0]            idx_i,
   output logic [7:0]            fcs_byte_o
);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (init_i) begin
         crc_d = CRC32_INIT;
      end else if (update_i) begin
         crc_d = crc32_next(data_i, crc_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_q <= CRC32_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign fcs_byte_o = ~crc_q[{idx_i, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: rtl/tx_mac_control.sv
// +---------------------------------------------------------------------------+
// | tx_mac_control : egress GMII MAC (preamble, pad, FCS, IFG, abort)         |
// | Optional: TX_STATS_EN adds internal frame/error/abort/pad counters.       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tx_mac_control
   import rx_tx_pkg::*;
#(
   parameter int MIN_FRAME_BYTES = TX_MIN_FRAME_BYTES,
   parameter int MAX_FRAME_BYTES = TX_MAX_FRAME_BYTES,
   parameter int IFG_BYTES       = TX_IFG_BYTES
) (
   input  logic                  switch_clk,
   input  logic                  switch_rst_n,
   input  logic [DATA_WIDTH-1:0] frame_data_i,
   input  logic                  frame_valid_i,
   input  logic                  frame_sof_i,
   input  logic                  frame_eof_i,
   input  logic                  frame_error_i,
   output logic                  frame_ready_o,
   output logic [DATA_WIDTH-1:0] gmii_tx_data_o,
   output logic                  gmii_tx_en_o,
   output logic                  gmii_tx_er_o
);

   localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME_BYTES);
   localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
   localparam logic [10:0] PRE_LAST = 11'd5;

   tx_state_t             state_q, state_d;
   logic [10:0]           count_q, count_d;
   logic [1:0]            fcs_idx_q, fcs_idx_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_en_q, tx_en_d;
   logic                  tx_er_q, tx_er_d;

   logic                  crc_init;
   logic                  crc_update;
   logic [DATA_WIDTH-1:0] crc_data;
   logic [7:0]            fcs_byte;
   logic                  w_proto_err;
   logic                  w_short;

   // Only the first accepted byte may carry sof; byte MAX+1 without eof is oversize.
   assign w_proto_err = (frame_sof_i && (count_q != 11'd0)) || (count_q >= MAX_CNT);
   assign w_short     = (count_q + 11'd1) < MIN_CNT;

   tx_fcs_gen u_fcs_gen (
      .clk_i      (switch_clk),
      .rst_ni     (switch_rst_n),
      .init_i     (crc_init),
      .update_i   (crc_update),
      .data_i     (crc_data),
      .idx_i      (fcs_idx_q),
      .fcs_byte_o (fcs_byte)
   );

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      fcs_idx_d     = fcs_idx_q;
      err_d         = err_q;
      tx_data_d     = '0;
      tx_en_d       = 1'b0;
      tx_er_d       = 1'b0;
      crc_init      = 1'b0;
      crc_update    = 1'b0;
      crc_data      = frame_data_i;
      frame_ready_o = 1'b0;

      unique case (state_q)
         TX_IDLE: begin
            crc_init  = 1'b1;
            count_d   = '0;
            fcs_idx_d = '0;
            err_d     = 1'b0;
            if (frame_valid_i && frame_sof_i) begin
               state_d   = TX_PREAMBLE;
               tx_en_d   = 1'b1;
               tx_data_d = PREAMBLE_BYTE;
            end
         end
         TX_PREAMBLE: begin
            tx_en_d   = 1'b1;
            tx_data_d = PREAMBLE_BYTE;
            if (count_q == PRE_LAST) begin
               count_d = '0;
               state_d = TX_SFD;
            end else begin
               count_d = count_q + 11'd1;
            end
         end
         TX_SFD: begin
            tx_en_d   = 1'b1;
            tx_data_d = SFD_BYTE;
            state_d   = TX_DATA;
         end
         TX_DATA: begin
            frame_ready_o = 1'b1;
            tx_en_d       = 1'b1;
            if (!frame_valid_i || w_proto_err) begin
               tx_er_d = 1'b1;
               count_d = '0;
               state_d = TX_IFG;
            end else begin
               tx_data_d  = frame_data_i;
               crc_update = 1'b1;
               count_d    = (count_q == 11'h7FF) ? count_q : count_q + 11'd1;
               if (frame_eof_i) begin
                  err_d   = frame_error_i;
                  state_d = w_short ? TX_PAD : TX_FCS;
               end
            end
         end
         TX_PAD: begin
            tx_en_d    = 1'b1;
            crc_data   = '0;
            crc_update = 1'b1;
            count_d    = count_q + 11'd1;
            if ((count_q + 11'd1) >= MIN_CNT) begin
               state_d = TX_FCS;
            end
         end
         TX_FCS: begin
            tx_en_d   = 1'b1;
            tx_er_d   = err_q;
            tx_data_d = fcs_byte;
            fcs_idx_d = fcs_idx_q + 2'd1;
            if (fcs_idx_q == 2'd3) begin
               count_d = '0;
               state_d = TX_IFG;
            end
         end
         TX_IFG: begin
            if (count_q == IFG_LAST) begin
               count_d = '0;
               state_d = TX_IDLE;
            end else begin
               count_d = count_q + 11'd1;
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         state_q   <= TX_IDLE;
         count_q   <= '0;
         fcs_idx_q <= '0;
         err_q     <= 1'b0;
         tx_data_q <= '0;
         tx_en_q   <= 1'b0;
         tx_er_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         fcs_idx_q <= fcs_idx_d;
         err_q     <= err_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
         tx_er_q   <= tx_er_d;
      end
   end

   assign gmii_tx_data_o = tx_data_q;
   assign gmii_tx_en_o   = tx_en_q;
   assign gmii_tx_er_o   = tx_er_q;

`ifdef TX_STATS_EN
   logic [31:0] tx_frame_count_q;
   logic [31:0] tx_error_frame_count_q;
   logic [31:0] tx_abort_count_q;
   logic [31:0] tx_pad_count_q;
   logic        w_frame_done;
   logic        w_abort;
   logic        w_pad;

   assign w_frame_done = (state_q == TX_FCS) && (fcs_idx_q == 2'd3);
   assign w_abort      = (state_q == TX_DATA) && (!frame_valid_i || w_proto_err);
   assign w_pad        = (state_q == TX_DATA) && frame_valid_i && !w_proto_err &&
                         frame_eof_i && w_short;

   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         tx_frame_count_q       <= '0;
         tx_error_frame_count_q <= '0;
         tx_abort_count_q       <= '0;
         tx_pad_count_q         <= '0;
      end else begin
         if (w_frame_done)          tx_frame_count_q       <= tx_frame_count_q + 32'd1;
         if (w_frame_done && err_q) tx_error_frame_count_q <= tx_error_frame_count_q + 32'd1;
         if (w_abort)               tx_abort_count_q       <= tx_abort_count_q + 32'd1;
         if (w_pad)                 tx_pad_count_q         <= tx_pad_count_q + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_mac_control.sv
// +---------------------------------------------------------------------------+
// | tb_tx_mac_control : randomized self-checking bench for tx_mac_control     |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_tx_mac_control;

   logic       switch_clk = 1'b0;
   logic       switch_rst_n = 1'b0;
   logic [7:0] frame_data = 8'h00;
   logic       frame_valid = 1'b0;
   logic       frame_sof = 1'b0;
   logic       frame_eof = 1'b0;
   logic       frame_error = 1'b0;
   logic       frame_ready;
   logic [7:0] tx_data;
   logic       tx_en;
   logic       tx_er;

   int n_chk = 0;
   int n_err = 0;

   // Bytes to present, in order, with their side-band flags.
   logic [7:0] s_data[$];
   bit         s_sof[$];
   bit         s_eof[$];
   bit         s_err[$];
   // Observed {en, er, data} per cycle and the expected stream.
   logic [9:0] cap[$];
   logic [9:0] exp_q[$];
   bit         cap_en = 1'b0;
   int         sof_idx = -1;

   tx_mac_control dut (
      .switch_clk     (switch_clk),
      .switch_rst_n   (switch_rst_n),
      .frame_data_i   (frame_data),
      .frame_valid_i  (frame_valid),
      .frame_sof_i    (frame_sof),
      .frame_eof_i    (frame_eof),
      .frame_error_i  (frame_error),
      .frame_ready_o  (frame_ready),
      .gmii_tx_data_o (tx_data),
      .gmii_tx_en_o   (tx_en),
      .gmii_tx_er_o   (tx_er)
   );

   always #5 switch_clk = ~switch_clk;

   always @(negedge switch_clk) begin
      if (cap_en) cap.push_back({tx_en, tx_er, tx_data});
   end

   always @(posedge switch_clk) begin
      if (cap_en && sof_idx < 0 && frame_valid && frame_sof) sof_idx = cap.size();
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] crc_of(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'd0, q[i]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic void add_frame(input logic [7:0] b[$], input bit err, input bit with_eof);
      foreach (b[i]) begin
         s_data.push_back(b[i]);
         s_sof.push_back(i == 0);
         s_eof.push_back(with_eof && (i == b.size() - 1));
         s_err.push_back(err && with_eof && (i == b.size() - 1));
      end
   endfunction

   function automatic void exp_header();
      repeat (7) exp_q.push_back({2'b10, 8'h55});
      exp_q.push_back({2'b10, 8'hD5});
   endfunction

   function automatic void exp_idle();
      repeat (12) exp_q.push_back(10'h000);
   endfunction

   function automatic void exp_good(input logic [7:0] b[$], input bit err);
      logic [7:0]  p[$];
      logic [31:0] c;
      p = b;
      while (p.size() < 60) p.push_back(8'h00);
      c = crc_of(p);
      exp_header();
      foreach (p[i]) exp_q.push_back({2'b10, p[i]});
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, err, ~c[8*k +: 8]});
      exp_idle();
   endfunction

   function automatic void exp_abort(input logic [7:0] b[$]);
      exp_header();
      foreach (b[i]) exp_q.push_back({2'b10, b[i]});
      exp_q.push_back({2'b11, 8'h00});
      exp_idle();
   endfunction

   function automatic void rand_bytes(output logic [7:0] b[$], input int n);
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
   endfunction

   task automatic drive_stream();
      int i = 0;
      int guard = 0;
      while (i < s_data.size() && guard < 5000) begin
         @(negedge switch_clk);
         frame_valid = 1'b1;
         frame_data  = s_data[i];
         frame_sof   = s_sof[i];
         frame_eof   = s_eof[i];
         frame_error = s_err[i];
         if (frame_ready) i++;
         guard++;
      end
      if (guard >= 5000) check_eq("drive_timeout", 32'(i), 32'(s_data.size()));
      @(negedge switch_clk);
      frame_valid = 1'b0;
      frame_sof   = 1'b0;
      frame_eof   = 1'b0;
      frame_error = 1'b0;
   endtask

   // Drives the queued stream, then compares the captured GMII cycles with exp_q.
   task automatic run_case(input string tag, input int payload_len, input bit chk_residue);
      int first = -1;
      int en_got = 0;
      int en_exp = 0;
      logic [7:0] rq[$];
      cap.delete();
      sof_idx = -1;
      cap_en  = 1'b1;
      drive_stream();
      repeat (90) @(negedge switch_clk);
      cap_en = 1'b0;
      foreach (cap[i]) begin
         if (first < 0 && cap[i][9]) first = i;
         if (cap[i][9]) en_got++;
      end
      foreach (exp_q[i]) if (exp_q[i][9]) en_exp++;
      check_eq({tag, "_en_cycles"}, 32'(en_got), 32'(en_exp));
      if (first < 0) begin
         check_eq({tag, "_no_tx_en"}, 32'(first), 32'(sof_idx));
      end else begin
         check_eq({tag, "_start"}, 32'(first), 32'(sof_idx));
         foreach (exp_q[i]) begin
            check_eq($sformatf("%s_cyc%0d", tag, i),
                     (first + i < cap.size()) ? 32'(cap[first + i]) : 32'hFFFF, 32'(exp_q[i]));
         end
         if (chk_residue && first + 8 + payload_len + 4 <= cap.size()) begin
            for (int i = 0; i < payload_len + 4; i++) rq.push_back(cap[first + 8 + i][7:0]);
            check_eq({tag, "_residue"}, crc_of(rq), 32'hDEBB20E3);
         end
      end
      check_eq({tag, "_ready_idle"}, 32'(frame_ready), 32'd0);
      s_data.delete(); s_sof.delete(); s_eof.delete(); s_err.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] a[$];
      logic [7:0] b[$];
      int         n;
      bit         e;

      repeat (3) @(negedge switch_clk);
      check_eq("rst_en",    32'(tx_en),       32'd0);
      check_eq("rst_er",    32'(tx_er),       32'd0);
      check_eq("rst_data",  32'(tx_data),     32'd0);
      check_eq("rst_ready", 32'(frame_ready), 32'd0);
      switch_rst_n = 1'b1;

      // valid without sof in IDLE must be ignored
      frame_valid = 1'b1;
      frame_data  = 8'h3C;
      repeat (4) @(negedge switch_clk);
      check_eq("nosof_ready", 32'(frame_ready), 32'd0);
      check_eq("nosof_en",    32'(tx_en),       32'd0);
      frame_valid = 1'b0;
      @(negedge switch_clk);

      rand_bytes(a, 60); add_frame(a, 1'b0, 1'b1); exp_good(a, 1'b0);
      run_case("full60", 60, 1'b1);

      rand_bytes(a, 20); add_frame(a, 1'b0, 1'b1); exp_good(a, 1'b0);
      run_case("short20", 60, 1'b1);

      rand_bytes(a, 61); rand_bytes(b, 1);
      add_frame(a, 1'b0, 1'b1); add_frame(b, 1'b0, 1'b1);
      exp_good(a, 1'b0); exp_good(b, 1'b0);
      run_case("b2b", 61, 1'b1);

      rand_bytes(a, 29); add_frame(a, 1'b0, 1'b0); exp_abort(a);
      run_case("underrun", 0, 1'b0);

      rand_bytes(a, 64); add_frame(a, 1'b1, 1'b1); exp_good(a, 1'b1);
      run_case("err_eof", 64, 1'b1);

      rand_bytes(a, 5); add_frame(a, 1'b0, 1'b0);
      s_data.push_back(8'hA5); s_sof.push_back(1'b1); s_eof.push_back(1'b0); s_err.push_back(1'b0);
      exp_abort(a);
      run_case("sof_err", 0, 1'b0);

      rand_bytes(a, 1515); add_frame(a, 1'b0, 1'b0);
      b = a; void'(b.pop_back()); exp_abort(b);
      run_case("oversize", 0, 1'b0);

      rand_bytes(a, 1514); add_frame(a, 1'b0, 1'b1); exp_good(a, 1'b0);
      run_case("max1514", 1514, 1'b1);

      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(1, 120);
         e = 1'($urandom);
         rand_bytes(a, n); add_frame(a, e, 1'b1); exp_good(a, e);
         run_case($sformatf("rand%0d", r), (n < 60) ? 60 : n, 1'b1);
      end

      // reset mid-frame
      @(negedge switch_clk);
      frame_valid = 1'b1; frame_sof = 1'b1; frame_data = 8'h11;
      repeat (8) @(negedge switch_clk);
      check_eq("sfd_ready", 32'(frame_ready), 32'd1);
      check_eq("sfd_data",  32'(tx_data),     32'hD5);
      @(negedge switch_clk);
      frame_sof = 1'b0; frame_data = 8'h22;
      repeat (5) @(negedge switch_clk);
      check_eq("pre_rst_en", 32'(tx_en), 32'd1);
      #2 switch_rst_n = 1'b0;
      #1;
      check_eq("async_rst_en",    32'(tx_en),       32'd0);
      check_eq("async_rst_er",    32'(tx_er),       32'd0);
      check_eq("async_rst_ready", 32'(frame_ready), 32'd0);
      frame_valid = 1'b0;
      @(negedge switch_clk);
      switch_rst_n = 1'b1;
      @(negedge switch_clk);

      rand_bytes(a, 33); add_frame(a, 1'b0, 1'b1); exp_good(a, 1'b0);
      run_case("after_rst", 60, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
